// File: rtl/popcount_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_axil_slave
//  Description : AXI4-Lite register slave for the PopCount IP. Four 32-bit
//                RW operand/scratch registers and a read-only RESULT register
//                driven by a four-cycle, byte-serial population-count engine
//                that is started by any write to REG0.
//  Revision    : 1.0  initial release
// ============================================================================
module popcount_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    // write response channel
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int         c_NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    // engine state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_COUNT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // Register storage and channel state
    // ------------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];

    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    // engine state
    logic [1:0]                    r_state;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_snap;
    logic [1:0]                    r_idx;
    logic [5:0]                    r_count;
    logic                          r_busy;
    logic                          r_done;

    // ------------------------------------------------------------------------
    // Write-path decode
    // ------------------------------------------------------------------------
    logic                          w_wr_fire;
    logic [2:0]                    w_wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_old;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_new;
    logic                          w_start;

    assign w_wr_fire = r_awready & S_AXI_AWVALID & r_wready & S_AXI_WVALID;
    assign w_wr_idx  = S_AXI_AWADDR[4:2];
    assign w_wr_old  = r_regs[w_wr_idx[1:0]];
    // only a REG0 handshake starts (or restarts) the engine
    assign w_start   = w_wr_fire & (w_wr_idx == 3'd0);

    // byte-lane merge of new write data over the current register contents
    for (genvar b = 0; b < c_NUM_BYTES; b++) begin : g_strb
        assign w_wr_new[8*b +: 8] = S_AXI_WSTRB[b] ? S_AXI_WDATA[8*b +: 8]
                                                   : w_wr_old[8*b +: 8];
    end

    // ------------------------------------------------------------------------
    // Read-path decode
    // ------------------------------------------------------------------------
    logic                          w_rd_fire;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_result;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_mux;

    assign w_rd_fire = r_arready & S_AXI_ARVALID;
    assign w_result  = {r_busy, r_done, 24'd0, r_count};

    // read data select; unmapped slots read as zero
    always_comb begin
        w_rd_mux = '0;
        case (S_AXI_ARADDR[4:2])
            3'd0:    w_rd_mux = r_regs[0];
            3'd1:    w_rd_mux = r_regs[1];
            3'd2:    w_rd_mux = r_regs[2];
            3'd3:    w_rd_mux = r_regs[3];
            3'd4:    w_rd_mux = w_result;
            default: w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Popcount of the snapshot byte currently selected by the engine
    // ------------------------------------------------------------------------
    logic [7:0] w_byte;
    logic [3:0] w_byte_pop;

    // count the set bits of one byte (0..8)
    always_comb begin
        w_byte     = r_snap[{r_idx, 3'b000} +: 8];
        w_byte_pop = '0;
        for (int i = 0; i < 8; i++) begin
            w_byte_pop = w_byte_pop + {3'b000, w_byte[i]};
        end
    end

    // ------------------------------------------------------------------------
    // Write address/data acceptance and response
    // ------------------------------------------------------------------------
    // ready pulses for one cycle when both halves are present and no
    // response is outstanding; bvalid is raised on the accepting edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= ~r_awready & S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
            r_wready  <= ~r_wready  & S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operand register file; RESULT and unmapped writes are dropped
    // ------------------------------------------------------------------------
    // strobe-merged update of REG0..REG3
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire && !w_wr_idx[2]) begin
            r_regs[w_wr_idx[1:0]] <= w_wr_new;
        end
    end

    // ------------------------------------------------------------------------
    // Read address acceptance and data return
    // ------------------------------------------------------------------------
    // data is sampled on the accepting edge and held until consumed
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= ~r_arready & S_AXI_ARVALID & ~r_rvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Popcount engine: one byte per cycle, four cycles, sticky done
    // ------------------------------------------------------------------------
    // a REG0 write always wins, so a write mid-count simply restarts
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= c_ST_IDLE;
            r_snap  <= '0;
            r_idx   <= 2'd0;
            r_count <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_start) begin
            r_state <= c_ST_COUNT;
            r_snap  <= w_wr_new;
            r_idx   <= 2'd0;
            r_count <= 6'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_COUNT: begin
                    r_count <= r_count + {2'b00, w_byte_pop};
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_IDLE, c_ST_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = c_RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = c_RESP_OKAY;

    // protection bits and byte offsets carry no meaning for this slave
    logic w_unused_ok;
    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_popcount_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_axil_slave
//  Description : Scoreboard testbench for popcount_axil_slave. Stimulus
//                pushes expected read data into a queue; a monitor pops and
//                compares on every R handshake and checks every B response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_popcount_axil_slave;

    logic        clk;
    logic        rst_n;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;

    // scoreboard: expected read data and the bits that matter
    logic [31:0] exp_q  [$];
    logic [31:0] mask_q [$];

    // reference model of the register map
    logic [31:0] m_regs [4];
    logic [31:0] m_res;

    popcount_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Reference helpers
    // ------------------------------------------------------------------------
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] done_result(input logic [31:0] v);
        return 32'h4000_0000 | 32'($countones(v));
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx < 4)  return m_regs[idx];
        if (idx == 4) return m_res;
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // ------------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("b_response");
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp,
                            input logic [31:0] mask);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("ar_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("r_response");
        @(posedge clk); #1;
    endtask

    // write through the model; a REG0 write waits out the engine latency
    task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        axi_write(5'(idx * 4), data, strb);
        if (idx < 4) m_regs[idx] = merge(m_regs[idx], data, strb);
        if (idx == 0) begin
            repeat (6) @(negedge clk);
            m_res = done_result(m_regs[0]);
        end
    endtask

    task automatic do_read(input int idx);
        axi_read(5'(idx * 4), model_read(idx), 32'hFFFF_FFFF);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares every response against the scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                total++;
                if (bresp !== 2'b00) begin
                    bad++;
                    $display("FAIL bresp: got %b expected 00", bresp);
                end
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_r: got %h expected no response", rdata);
                end else begin
                    logic [31:0] e;
                    logic [31:0] m;
                    e = exp_q.pop_front();
                    m = mask_q.pop_front();
                    total++;
                    if (((rdata & m) !== (e & m)) || (rresp !== 2'b00)) begin
                        bad++;
                        $display("FAIL rdata: got %h resp %b expected %h (mask %h) resp 00",
                                 rdata, rresp, e, m);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_res = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {24'd0, awready, wready, bvalid, arready, rvalid, bresp, rresp} , 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // reset state of the register map
        for (int i = 0; i < 5; i++) do_read(i);

        // sequential write / read-back
        for (int i = 0; i < 4; i++) do_write(i, 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) do_read(i);

        // popcount: busy on an immediate poll, then done with full count
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF);
        m_regs[0] = 32'hFFFF_FFFF;
        axi_read(5'h10, 32'h8000_0000, 32'hC000_0000);
        repeat (6) @(negedge clk);
        m_res = done_result(m_regs[0]);
        chk("model_all_ones", m_res, 32'h4000_0020);
        do_read(4);
        do_write(0, 32'h0000_0000, 4'hF);
        do_read(4);
        do_write(0, 32'h8000_0001, 4'hF);
        do_read(4);

        // RESULT is read-only
        do_write(4, 32'hFFFF_FFFF, 4'hF);
        do_read(4);

        // byte strobes
        do_write(1, 32'h1122_3344, 4'hF);
        do_write(1, 32'hAABB_CCDD, 4'b0101);
        chk("model_strobe", m_regs[1], 32'h11BB_33DD);
        do_read(1);

        // restart mid-count
        axi_write(5'h00, 32'h0000_FFFF, 4'hF);
        do_write(0, 32'h0000_0003, 4'hF);
        do_read(4);

        // write back-pressure with a second write pending
        begin
            int n;
            bready = 1'b0;
            @(negedge clk);
            awaddr = 5'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
            awvalid = 1'b1; wvalid = 1'b1;
            n = 0;
            while (!awready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) timeout("bp_aw1");
            @(posedge clk); #1;
            m_regs[2] = 32'hDEAD_BEEF;
            awaddr = 5'h0C; wdata = 32'h0BAD_F00D;
            repeat (10) begin
                @(negedge clk);
                chk("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
                chk("bp_awready_low", {31'd0, awready}, 32'd0);
            end
            @(posedge clk); #1;
            bready = 1'b1;
            n = 0;
            while (!awready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) timeout("bp_aw2");
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
            m_regs[3] = 32'h0BAD_F00D;
            n = 0;
            while (!bvalid && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) timeout("bp_b2");
        end
        do_read(2);
        do_read(3);

        // simultaneous read and write to different registers
        begin
            logic [31:0] exp_r1;
            exp_r1 = m_regs[1];
            fork
                axi_write(5'h0C, 32'hCAFE_0123, 4'hF);
                axi_read(5'h04, exp_r1, 32'hFFFF_FFFF);
            join
            m_regs[3] = 32'hCAFE_0123;
        end
        do_read(3);

        // unmapped read
        do_read(6);

        // randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            int idx;
            idx = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                do_write(idx, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                do_read(idx);
            end
        end

        // reset in the middle of a count
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {24'd0, awready, wready, bvalid, arready, rvalid, bresp, rresp}, 32'd0);
        chk("midreset_rdata", rdata, 32'd0);
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_read(4);
        do_read(0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
